// File: rtl/dmem_stall_responder.sv
// -----------------------------------------------------------------------------
// dmem_stall_responder
//
// Multi-cycle data-memory responder placed behind the memory pipeline stage.
// One read or write request is accepted at a time. The pipeline is held with
// Stall for LATENCY cycles, then the request completes with a one-cycle Done
// pulse, carrying read data on DataOut or an error flag on Err. It stands in
// for a single-cycle data memory so that stall/freeze logic gets exercised.
//
// Parameters
//   DEPTH    number of 16-bit words (power of 2); byte space is 2*DEPTH
//   LATENCY  cycles from acceptance to Done, 2..15
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-low reset
//   Addr[15:0]  in   byte address; word index Addr[log2(DEPTH):1], upper bits wrap
//   DataIn[15:0]in   write data
//   Rd, Wr      in   read / write request (both set = illegal request)
//   createdump  in   simulation-only array dump request, honoured in IDLE only
//   DataOut     out  read data, valid from the read Done cycle until the next read Done
//   Done        out  one-cycle completion pulse
//   Stall       out  hold the memory stage and everything upstream
//   Busy        out  request in flight
//   Err         out  one-cycle pulse with Done for an illegal request
//
// Build option
//   DMEM_ALIGN_CHECK_EN  when defined, an accepted request with Addr[0]=1 is
//                        illegal (no array access, Err with Done). When not
//                        defined, Addr[0] is ignored.
// -----------------------------------------------------------------------------
module dmem_stall_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Busy,
    output logic        Err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_stall_responder: LATENCY must be in 2..15");
    end

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic          r_rd_ok;
    logic          r_err;
    logic [15:0]   r_dout;
    logic [15:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_accept;
    logic          w_illegal;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_req    = Rd | Wr;
    assign w_accept = (r_state == S_IDLE) && w_req;
    // Byte address to word index; bits above the array simply wrap.
    assign w_idx    = Addr[AW:1];
    assign w_unused_addr = ^Addr;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_illegal = (Rd & Wr) | Addr[0];
`else
    assign w_illegal = Rd & Wr;
`endif

    // Control state and the read-data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_rd_ok <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_idx   <= w_idx;
                        r_rd_ok <= Rd & ~w_illegal;
                        r_err   <= w_illegal;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                        // Read data is sampled as late as possible so that an
                        // immediately preceding write is always observed.
                        if (r_rd_ok) begin
                            r_dout <= r_mem[r_idx];
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Array: written on the acceptance edge, never reset. The rst gate keeps a
    // request presented during reset from landing in the array.
    always_ff @(posedge clk) begin
        if (rst && w_accept && Wr && !w_illegal) begin
            r_mem[w_idx] <= DataIn;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && (r_state == S_IDLE) && createdump && !w_req) begin
            for (int i = 0; i < DEPTH; i++) begin
                $display("dmem[%0d] = %h", i, r_mem[i]);
            end
        end
    end
`endif

    assign DataOut = r_dout;
    assign Done    = (r_state == S_RESP);
    assign Err     = (r_state == S_RESP) && r_err;
    assign Busy    = (r_state != S_IDLE);
    // Stall drops in RESP so the pipeline advances on the Done edge.
    assign Stall   = w_accept || (r_state == S_WAIT);

endmodule
